// File: rtl/exu_oitf_pkg.sv
// Shared definitions for the outstanding-instruction tracking FIFO (OITF).
// The macros are the project-wide register-index width and default depth;
// the package re-exports them as typed localparams for the RTL.
`ifndef EXU_OITF_DEFINES
`define EXU_OITF_DEFINES
`define RFIDX_WIDTH 5
`define OITF_DEPTH  4
`endif

package exu_oitf_pkg;

    localparam int RFIDX_W        = `RFIDX_WIDTH;
    localparam int OITF_DEPTH_DEF = `OITF_DEPTH;

    // One tracked long-latency instruction.
    typedef struct packed {
        logic               valid;
        logic               rdwen;
        logic [RFIDX_W-1:0] rdidx;
    } oitf_ent_t;

endpackage

// File: rtl/exu_oitf_ent.sv
// Single OITF entry: holds valid/rdwen/rdidx of one outstanding instruction
// and reports whether its destination matches each register being checked.
module exu_oitf_ent
    import exu_oitf_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               set_i,
    input  logic               clr_i,
    input  logic               rdwen_i,
    input  logic [RFIDX_W-1:0] rdidx_i,
    input  logic [RFIDX_W-1:0] chk_rs1idx_i,
    input  logic [RFIDX_W-1:0] chk_rs2idx_i,
    input  logic [RFIDX_W-1:0] chk_rdidx_i,
    output logic               valid_o,
    output logic               rdwen_o,
    output logic [RFIDX_W-1:0] rdidx_o,
    output logic               match_rs1_o,
    output logic               match_rs2_o,
    output logic               match_rd_o
);

    oitf_ent_t ent_q;
    oitf_ent_t ent_d;
    logic      live_wr;

    // Next entry contents: flush wipes, allocation loads, retirement clears.
    always_comb begin
        ent_d = ent_q;
        if (flush_i) begin
            ent_d = '0;
        end else if (set_i) begin
            ent_d = '{valid: 1'b1, rdwen: rdwen_i, rdidx: rdidx_i};
        end else if (clr_i) begin
            ent_d = '0;
        end
    end

    // Entry storage, discarded immediately on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign live_wr     = ent_q.valid && ent_q.rdwen;
    assign valid_o     = ent_q.valid;
    assign rdwen_o     = ent_q.rdwen;
    assign rdidx_o     = ent_q.rdidx;
    assign match_rs1_o = live_wr && (ent_q.rdidx == chk_rs1idx_i);
    assign match_rs2_o = live_wr && (ent_q.rdidx == chk_rs2idx_i);
    assign match_rd_o  = live_wr && (ent_q.rdidx == chk_rdidx_i);

endmodule

// File: rtl/exu_oitf.sv
// Outstanding-instruction tracking FIFO: records destinations of in-flight
// long-latency instructions and flags RAW/WAW hazards for the instruction
// under dispatch. Pointers carry an extra wrap bit to tell full from empty.
module exu_oitf
    import exu_oitf_pkg::*;
#(
    parameter int DEPTH = OITF_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     alc_vld_i,
    output logic                     alc_rdy_o,
    input  logic                     alc_rdwen_i,
    input  logic [RFIDX_W-1:0]       alc_rdidx_i,
    output logic [$clog2(DEPTH)-1:0] alc_ptr_o,
    input  logic                     ret_vld_i,
    output logic [$clog2(DEPTH)-1:0] ret_ptr_o,
    output logic                     ret_rdwen_o,
    output logic [RFIDX_W-1:0]       ret_rdidx_o,
    input  logic                     chk_rs1en_i,
    input  logic                     chk_rs2en_i,
    input  logic                     chk_rdwen_i,
    input  logic [RFIDX_W-1:0]       chk_rs1idx_i,
    input  logic [RFIDX_W-1:0]       chk_rs2idx_i,
    input  logic [RFIDX_W-1:0]       chk_rdidx_i,
    output logic                     hzd_rs1_o,
    output logic                     hzd_rs2_o,
    output logic                     hzd_rd_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]        alc_ptr_q, alc_ptr_d;
    logic [PW:0]        ret_ptr_q, ret_ptr_d;
    logic [PW-1:0]      alc_idx, ret_idx;
    logic               full, empty;
    logic               alc_fire, ret_fire;

    logic               ent_valid [DEPTH];
    logic               ent_rdwen [DEPTH];
    logic [RFIDX_W-1:0] ent_rdidx [DEPTH];
    logic [DEPTH-1:0]   match_rs1, match_rs2, match_rd;

    assign alc_idx  = alc_ptr_q[PW-1:0];
    assign ret_idx  = ret_ptr_q[PW-1:0];
    assign empty    = (alc_ptr_q == ret_ptr_q);
    assign full     = (alc_idx == ret_idx) && (alc_ptr_q[PW] != ret_ptr_q[PW]);
    assign alc_fire = alc_vld_i && !full;
    assign ret_fire = ret_vld_i && !empty;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        exu_oitf_ent u_ent (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i),
            .set_i        (alc_fire && (alc_idx == PW'(i))),
            .clr_i        (ret_fire && (ret_idx == PW'(i))),
            .rdwen_i      (alc_rdwen_i),
            .rdidx_i      (alc_rdidx_i),
            .chk_rs1idx_i (chk_rs1idx_i),
            .chk_rs2idx_i (chk_rs2idx_i),
            .chk_rdidx_i  (chk_rdidx_i),
            .valid_o      (ent_valid[i]),
            .rdwen_o      (ent_rdwen[i]),
            .rdidx_o      (ent_rdidx[i]),
            .match_rs1_o  (match_rs1[i]),
            .match_rs2_o  (match_rs2[i]),
            .match_rd_o   (match_rd[i])
        );
    end

    // Pointer advance; flush returns both pointers to the start.
    always_comb begin
        alc_ptr_d = alc_ptr_q;
        ret_ptr_d = ret_ptr_q;
        if (flush_i) begin
            alc_ptr_d = '0;
            ret_ptr_d = '0;
        end else begin
            if (alc_fire) alc_ptr_d = alc_ptr_q + 1'b1;
            if (ret_fire) ret_ptr_d = ret_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alc_ptr_q <= '0;
            ret_ptr_q <= '0;
        end else begin
            alc_ptr_q <= alc_ptr_d;
            ret_ptr_q <= ret_ptr_d;
        end
    end

    assign alc_rdy_o   = !full;
    assign alc_ptr_o   = alc_idx;
    assign empty_o     = empty;
    assign ret_ptr_o   = empty ? '0 : ret_idx;
    assign ret_rdwen_o = ent_valid[ret_idx] && ent_rdwen[ret_idx];
    assign ret_rdidx_o = ent_valid[ret_idx] ? ent_rdidx[ret_idx] : '0;

    // Register x0 is never a real dependency, so index 0 never flags.
    assign hzd_rs1_o = chk_rs1en_i && (chk_rs1idx_i != '0) && (|match_rs1);
    assign hzd_rs2_o = chk_rs2en_i && (chk_rs2idx_i != '0) && (|match_rs2);
    assign hzd_rd_o  = chk_rdwen_i && (chk_rdidx_i  != '0) && (|match_rd);

endmodule

// File: tb/tb_exu_oitf.sv
// Self-checking bench for exu_oitf: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_exu_oitf;
    import exu_oitf_pkg::*;

    localparam int DEPTH = 4;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               flush_i, alc_vld_i, alc_rdwen_i, ret_vld_i;
    logic [RFIDX_W-1:0] alc_rdidx_i;
    logic               chk_rs1en_i, chk_rs2en_i, chk_rdwen_i;
    logic [RFIDX_W-1:0] chk_rs1idx_i, chk_rs2idx_i, chk_rdidx_i;
    logic               alc_rdy_o, ret_rdwen_o, hzd_rs1_o, hzd_rs2_o, hzd_rd_o, empty_o;
    logic [1:0]         alc_ptr_o, ret_ptr_o;
    logic [RFIDX_W-1:0] ret_rdidx_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        bit               rdwen;
        bit [RFIDX_W-1:0] rdidx;
    } m_ent_t;

    m_ent_t mq[$];
    int     allocCnt = 0;
    int     retCnt   = 0;

    typedef struct {
        logic               flush, alcVld, alcRdwen;
        logic [RFIDX_W-1:0] alcRdidx;
        logic               retVld;
        logic               rs1en;
        logic [RFIDX_W-1:0] rs1idx;
        logic               rs2en;
        logic [RFIDX_W-1:0] rs2idx;
        logic               rdwen;
        logic [RFIDX_W-1:0] rdidx;
        logic               expRdy, expEmpty;
        logic [1:0]         expAptr, expRptr;
        logic               expRetWen;
        logic [RFIDX_W-1:0] expRetIdx;
        logic               expH1, expH2, expHd;
    } vec_t;

    vec_t vecs[17];

    exu_oitf #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .alc_vld_i    (alc_vld_i),
        .alc_rdy_o    (alc_rdy_o),
        .alc_rdwen_i  (alc_rdwen_i),
        .alc_rdidx_i  (alc_rdidx_i),
        .alc_ptr_o    (alc_ptr_o),
        .ret_vld_i    (ret_vld_i),
        .ret_ptr_o    (ret_ptr_o),
        .ret_rdwen_o  (ret_rdwen_o),
        .ret_rdidx_o  (ret_rdidx_o),
        .chk_rs1en_i  (chk_rs1en_i),
        .chk_rs2en_i  (chk_rs2en_i),
        .chk_rdwen_i  (chk_rdwen_i),
        .chk_rs1idx_i (chk_rs1idx_i),
        .chk_rs2idx_i (chk_rs2idx_i),
        .chk_rdidx_i  (chk_rdidx_i),
        .hzd_rs1_o    (hzd_rs1_o),
        .hzd_rs2_o    (hzd_rs2_o),
        .hzd_rd_o     (hzd_rd_o),
        .empty_o      (empty_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        flush_i      = v.flush;
        alc_vld_i    = v.alcVld;
        alc_rdwen_i  = v.alcRdwen;
        alc_rdidx_i  = v.alcRdidx;
        ret_vld_i    = v.retVld;
        chk_rs1en_i  = v.rs1en;
        chk_rs1idx_i = v.rs1idx;
        chk_rs2en_i  = v.rs2en;
        chk_rs2idx_i = v.rs2idx;
        chk_rdwen_i  = v.rdwen;
        chk_rdidx_i  = v.rdidx;
    endtask

    task automatic clearInputs();
        vec_t z;
        z = '{default: '0};
        applyStimulus(z);
    endtask

    function automatic bit modelHzd(input bit en, input bit [RFIDX_W-1:0] idx);
        if (!en || idx == 0) return 1'b0;
        foreach (mq[k]) if (mq[k].rdwen && mq[k].rdidx == idx) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock; the model follows the FIFO rules using the inputs held at the edge.
    task automatic stepClock();
        bit doAlc, doRet;
        @(posedge clk_i);
        if (flush_i) begin
            mq.delete();
            allocCnt = 0;
            retCnt   = 0;
        end else begin
            doAlc = alc_vld_i && (mq.size() < DEPTH);
            doRet = ret_vld_i && (mq.size() > 0);
            if (doRet) begin
                void'(mq.pop_front());
                retCnt++;
            end
            if (doAlc) begin
                mq.push_back('{rdwen: alc_rdwen_i, rdidx: alc_rdidx_i});
                allocCnt++;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        clearInputs();
        chk_rs1en_i = 1'b1; chk_rs1idx_i = 5;
        chk_rdwen_i = 1'b1; chk_rdidx_i  = 5;
        #1;
        checkOutput("rst_alc_rdy", alc_rdy_o, 1);
        checkOutput("rst_empty", empty_o, 1);
        checkOutput("rst_alc_ptr", alc_ptr_o, 0);
        checkOutput("rst_ret_ptr", ret_ptr_o, 0);
        checkOutput("rst_ret_rdwen", ret_rdwen_o, 0);
        checkOutput("rst_ret_rdidx", ret_rdidx_o, 0);
        checkOutput("rst_hzd", {hzd_rs1_o, hzd_rs2_o, hzd_rd_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clearInputs();
        mq.delete();
        allocCnt = 0;
        retCnt   = 0;
    endtask

    task automatic checkAgainstModel(input string tag);
        bit ne;
        ne = (mq.size() != 0);
        checkOutput({tag, "_alc_rdy"}, alc_rdy_o, mq.size() < DEPTH);
        checkOutput({tag, "_empty"}, empty_o, !ne);
        checkOutput({tag, "_alc_ptr"}, alc_ptr_o, allocCnt % DEPTH);
        checkOutput({tag, "_ret_ptr"}, ret_ptr_o, ne ? retCnt % DEPTH : 0);
        checkOutput({tag, "_ret_rdwen"}, ret_rdwen_o, ne ? mq[0].rdwen : 1'b0);
        checkOutput({tag, "_ret_rdidx"}, ret_rdidx_o, ne ? mq[0].rdidx : '0);
        checkOutput({tag, "_hzd_rs1"}, hzd_rs1_o, modelHzd(chk_rs1en_i, chk_rs1idx_i));
        checkOutput({tag, "_hzd_rs2"}, hzd_rs2_o, modelHzd(chk_rs2en_i, chk_rs2idx_i));
        checkOutput({tag, "_hzd_rd"}, hzd_rd_o, modelHzd(chk_rdwen_i, chk_rdidx_i));
    endtask

    initial begin
        rst_ni = 1'b0;
        clearInputs();

        // flush alcVld alcRdwen alcRdidx retVld | rs1en rs1idx rs2en rs2idx rdwen rdidx |
        // rdy empty aptr rptr retwen retidx h1 h2 hd  (outputs checked before the edge)
        vecs[0]  = '{0,1,1,5,0, 1,5,0,0,0,0, 1,1,0,0,0,0, 0,0,0};
        vecs[1]  = '{0,0,0,0,0, 1,5,0,0,0,0, 1,0,1,0,1,5, 1,0,0};
        vecs[2]  = '{0,0,0,0,1, 1,5,0,0,0,0, 1,0,1,0,1,5, 1,0,0};
        vecs[3]  = '{0,0,0,0,0, 1,5,0,0,0,0, 1,1,1,0,0,0, 0,0,0};
        vecs[4]  = '{0,1,1,0,0, 0,0,1,0,0,0, 1,1,1,0,0,0, 0,0,0};
        vecs[5]  = '{0,1,0,7,0, 0,0,1,0,0,0, 1,0,2,1,1,0, 0,0,0};
        vecs[6]  = '{0,0,0,0,0, 1,7,1,0,1,7, 1,0,3,1,1,0, 0,0,0};
        vecs[7]  = '{1,1,1,3,1, 0,0,0,0,0,0, 1,0,3,1,1,0, 0,0,0};
        vecs[8]  = '{0,0,0,0,0, 1,7,1,0,1,7, 1,1,0,0,0,0, 0,0,0};
        vecs[9]  = '{0,1,1,9,1, 0,0,0,0,0,0, 1,1,0,0,0,0, 0,0,0};
        vecs[10] = '{0,0,0,0,0, 0,0,0,0,1,9, 1,0,1,0,1,9, 0,0,1};
        vecs[11] = '{0,1,1,1,0, 0,0,0,0,1,9, 1,0,1,0,1,9, 0,0,1};
        vecs[12] = '{0,1,1,2,0, 1,1,0,0,0,0, 1,0,2,0,1,9, 1,0,0};
        vecs[13] = '{0,1,1,3,0, 0,0,1,2,0,0, 1,0,3,0,1,9, 0,1,0};
        vecs[14] = '{0,1,1,4,0, 1,4,0,0,1,3, 0,0,0,0,1,9, 0,0,1};
        vecs[15] = '{0,0,0,0,1, 1,4,0,0,0,0, 0,0,0,0,1,9, 0,0,0};
        vecs[16] = '{0,0,0,0,0, 1,4,1,9,0,0, 1,0,0,1,1,1, 0,0,0};

        doReset();

        // Directed table: single alloc, retire, x0 and rdwen=0 filtering, flush, fill to full.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_alc_rdy", i), alc_rdy_o, vecs[i].expRdy);
            checkOutput($sformatf("vec%0d_empty", i), empty_o, vecs[i].expEmpty);
            checkOutput($sformatf("vec%0d_alc_ptr", i), alc_ptr_o, vecs[i].expAptr);
            checkOutput($sformatf("vec%0d_ret_ptr", i), ret_ptr_o, vecs[i].expRptr);
            checkOutput($sformatf("vec%0d_ret_rdwen", i), ret_rdwen_o, vecs[i].expRetWen);
            checkOutput($sformatf("vec%0d_ret_rdidx", i), ret_rdidx_o, vecs[i].expRetIdx);
            checkOutput($sformatf("vec%0d_hzd_rs1", i), hzd_rs1_o, vecs[i].expH1);
            checkOutput($sformatf("vec%0d_hzd_rs2", i), hzd_rs2_o, vecs[i].expH2);
            checkOutput($sformatf("vec%0d_hzd_rd", i), hzd_rd_o, vecs[i].expHd);
            stepClock();
        end

        // Steady alloc+retire with one entry in flight: pointers wrap, never full/empty.
        doReset();
        alc_vld_i = 1'b1; alc_rdwen_i = 1'b1; alc_rdidx_i = 20;
        stepClock();
        for (int i = 0; i < 10; i++) begin
            alc_vld_i = 1'b1; ret_vld_i = 1'b1; alc_rdidx_i = RFIDX_W'(21 + i);
            #1;
            checkOutput($sformatf("steady%0d_empty", i), empty_o, 0);
            checkOutput($sformatf("steady%0d_alc_rdy", i), alc_rdy_o, 1);
            checkOutput($sformatf("steady%0d_alc_ptr", i), alc_ptr_o, (1 + i) % 4);
            checkOutput($sformatf("steady%0d_ret_ptr", i), ret_ptr_o, i % 4);
            checkOutput($sformatf("steady%0d_ret_rdidx", i), ret_rdidx_o, 20 + i);
            stepClock();
        end
        clearInputs();

        // Asynchronous reset in the middle of a cycle drops entries at once.
        alc_vld_i = 1'b1; alc_rdwen_i = 1'b1; alc_rdidx_i = 6;
        stepClock();
        alc_vld_i = 1'b1; ret_vld_i = 1'b1;
        chk_rs1en_i = 1'b1; chk_rs1idx_i = 6;
        #1;
        checkOutput("arst_pre_hzd_rs1", hzd_rs1_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_empty", empty_o, 1);
        checkOutput("arst_hzd_rs1", hzd_rs1_o, 0);
        checkOutput("arst_alc_ptr", alc_ptr_o, 0);
        checkOutput("arst_alc_rdy", alc_rdy_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clearInputs();
        mq.delete();
        allocCnt = 0;
        retCnt   = 0;

        // Randomized traffic against the queue model; narrow index range to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            flush_i      = ($urandom_range(0, 29) == 0);
            alc_vld_i    = ($urandom_range(0, 9) < 6);
            alc_rdwen_i  = ($urandom_range(0, 3) != 0);
            alc_rdidx_i  = RFIDX_W'($urandom_range(0, 7));
            ret_vld_i    = ($urandom_range(0, 9) < 5);
            chk_rs1en_i  = $urandom_range(0, 1);
            chk_rs2en_i  = $urandom_range(0, 1);
            chk_rdwen_i  = $urandom_range(0, 1);
            chk_rs1idx_i = RFIDX_W'($urandom_range(0, 7));
            chk_rs2idx_i = RFIDX_W'($urandom_range(0, 7));
            chk_rdidx_i  = RFIDX_W'($urandom_range(0, 7));
            #1;
            checkAgainstModel($sformatf("rnd%0d", c));
            stepClock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/exu_oitf.md
EXU_OITF -- requirements
Module: exu_oitf

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of outstanding-instruction entries (power of two, >=2).
REQ-002 SHALL use `RFIDX_WIDTH (defines.v) for all register-index widths; PW = log2(DEPTH).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  discard all outstanding entries.
REQ-006 alc_vld  in  1  dispatch requests allocation of a long-latency instruction.
REQ-007 alc_rdy  out  1  entry available (not full).
REQ-008 alc_rdwen  in  1  allocated instruction writes rd.
REQ-009 alc_rdidx  in  `RFIDX_WIDTH  allocated instruction's rd.
REQ-010 alc_ptr  out  PW  index the allocation lands in this cycle.
REQ-011 ret_vld  in  1  writeback retires the oldest entry.
REQ-012 ret_ptr  out  PW  index of oldest entry.
REQ-013 ret_rdwen  out  1  oldest entry writes rd.
REQ-014 ret_rdidx  out  `RFIDX_WIDTH  oldest entry's rd.
REQ-015 chk_rs1en  in  1  instruction under dispatch reads rs1.
REQ-016 chk_rs2en  in  1  instruction under dispatch reads rs2.
REQ-017 chk_rdwen  in  1  instruction under dispatch writes rd.
REQ-018 chk_rs1idx / chk_rs2idx / chk_rdidx  in  `RFIDX_WIDTH each  indices checked (three ports).
REQ-019 hzd_rs1 / hzd_rs2 / hzd_rd  out  1 each  RAW-rs1, RAW-rs2, WAW hazard flags (three ports).
REQ-020 empty  out  1  no valid entries.

Function
REQ-021 SHALL implement a circular FIFO: alloc and retire pointers of PW+1 bits (wrap bit); full = indices equal, wrap bits differ; empty = pointers equal.
REQ-022 alc_rdy SHALL equal !full; allocation fires on alc_vld && alc_rdy, writing {valid=1, rdwen, rdidx} at alc_ptr; alc_ptr advances by 1 next cycle, wrapping DEPTH-1 -> 0 and toggling wrap bit.
REQ-023 ret_vld while empty SHALL be ignored (no pointer move, no state change); otherwise oldest entry cleared, retire pointer advances next cycle.
REQ-024 ret_ptr, ret_rdwen, ret_rdidx SHALL be combinational from the oldest entry, zero when empty.
REQ-025 Alloc and retire in same cycle SHALL both take effect (occupancy unchanged); when full only retire proceeds; when empty the retire is ignored and alloc proceeds.
REQ-026 hzd_rs1 = chk_rs1en && chk_rs1idx!=0 && any valid entry with rdwen && rdidx==chk_rs1idx; hzd_rs2 likewise; hzd_rd uses chk_rdwen/chk_rdidx.
REQ-027 Hazard outputs SHALL be combinational (zero latency), exclude the entry being allocated this cycle, and include an entry retiring this cycle.
REQ-028 flush SHALL, next edge, clear all valid bits and both pointers to 0, overriding same-cycle alloc and retire.

Reset
REQ-029 On rst low: pointers 0, all valid bits 0; outputs alc_rdy=1, empty=1, alc_ptr=0, ret_ptr=0, ret_rdwen=0, ret_rdidx=0, hzd_*=0.
REQ-030 Reset mid-operation SHALL discard all entries immediately (asynchronous), regardless of alc_vld/ret_vld.

Structure
REQ-031 DEPTH default and entry-field widths SHALL be macros in shared defines.v alongside `RFIDX_WIDTH.
REQ-032 One sub-module natural: exu_oitf_ent (single entry register with valid/rdwen/rdidx and compare outputs), instantiated DEPTH times.

Verification
REQ-033 Reset, then alloc rd=5 rdwen=1 -> next cycle empty=0, ret_ptr=0, ret_rdidx=5; chk_rs1en=1 idx=5 -> hzd_rs1=1.
REQ-034 Alloc 4 entries (rd=1..4) with no retire -> alc_rdy=0 after 4th; 5th alc_vld ignored; retire one -> alc_rdy=1, ret_rdidx=2.
REQ-035 Repeated alloc+retire same cycle for 10 cycles -> occupancy constant at 1, alc_ptr wraps 3->0, no spurious full/empty.
REQ-036 chk_rs2idx=0 with an entry rd=0 rdwen=1 -> hzd_rs2=0; entry rdwen=0 rd=7, chk_rdidx=7 chk_rdwen=1 -> hzd_rd=0.
REQ-037 3 valid entries, flush with alc_vld and ret_vld high -> next cycle empty=1, alc_ptr=0, ret_ptr=0, all hzd_*=0.
REQ-038 ret_vld on empty OITF with alc_vld high -> one entry allocated, retire pointer unchanged.
